// File: rtl/turbo_encoder_blk_if.sv
// ---------------------------------------------------------------------------
// turbo_encoder_blk_if
//   Handshake bundle for the block turbo encoder.
//   Input side : in_valid / in_ready / in_bit      (serial information bits)
//   Output side: out_valid / out_ready / out_data  (one {sys,p1,p2} symbol
//                per transfer) plus out_tail / out_last markers
//   Status     : busy (encoder is not in its LOAD phase)
//   Modports   : master = bit source + downstream consumer (testbench side)
//                slave  = encoder
// ---------------------------------------------------------------------------
interface turbo_encoder_blk_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_tail;
  logic       out_last;
  logic       busy;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, out_tail, out_last, busy
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, out_tail, out_last, busy
  );
endinterface

// File: rtl/turbo_encoder_blk.sv
// ---------------------------------------------------------------------------
// turbo_encoder_blk
//   Rate-1/3 parallel-concatenated convolutional (turbo) encoder with a
//   K-bit block buffer. A block of K bits is loaded serially, then K symbols
//   {sys, p1, p2} are emitted, followed by 3 termination symbols for RSC1 and
//   3 for RSC2 (K+6 symbols per block). RSC2 is fed with the QPP-interleaved
//   sequence buf[pi(i)], pi(i) = (F1*i + F2*i*i) mod K, generated
//   incrementally without a multiplier.
//
//   Optional feature macro: TURBO_PUNCT_EN
//     defined   -> rate-1/2 puncturing of data symbols: {sys, p, 0} with
//                  p = z1 for even i, z2 for odd i; tail symbols unchanged.
//     undefined -> plain rate-1/3 output.
//
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-low reset
//     bus  : turbo_encoder_blk_if.slave
//              in_valid/in_ready/in_bit   - serial bit input
//              out_valid/out_ready        - output handshake
//              out_data                   - {sys, p1, p2}, MSB = sys
//              out_tail                   - symbol is a termination symbol
//              out_last                   - final symbol of the block
//              busy                       - high outside the LOAD phase
//
//   Parameters: K (block length, >= 8), F1, F2 (QPP coefficients).
// ---------------------------------------------------------------------------
module turbo_encoder_blk #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  turbo_encoder_blk_if.slave  bus
);

  localparam int AW = $clog2(K);

  // Constant increments of the QPP recurrence, pre-reduced mod K so every
  // runtime step is a single add + conditional subtract.
  localparam int GINIT = (F1 + F2) % K;
  localparam int GSTEP = (2 * F2) % K;

  localparam logic [AW:0]   K_W     = (AW+1)'(K);
  localparam logic [AW:0]   GSTEP_W = (AW+1)'(GSTEP);
  localparam logic [AW-1:0] GINIT_A = AW'(GINIT);
  localparam logic [AW-1:0] LAST_A  = AW'(K - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ENC   = 2'd1,
    TERM1 = 2'd2,
    TERM2 = 2'd3
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] wcnt_reg;
  logic [AW-1:0] icnt_reg;
  logic [AW-1:0] pi_reg;
  logic [AW-1:0] g_reg;
  logic [1:0]    tcnt_reg;
  // RSC states packed as {s3, s2, s1}
  logic [2:0]    rsc1_reg;
  logic [2:0]    rsc2_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic [2:0]    out_data_reg;
  logic          out_tail_reg;
  logic          out_last_reg;

  // Block buffer. Two independent read addresses (linear and interleaved)
  // are needed every cycle, and one bit per entry is tiny, so reads are
  // asynchronous and the array maps to distributed memory.
  logic buf_mem [K];

  always_ff @(posedge clk) begin
    if (rst && state_reg == LOAD && bus.in_valid && in_ready_reg) begin
      buf_mem[wcnt_reg] <= bus.in_bit;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: encoder outputs for the current step
  // ---------------------------------------------------------------------
  logic          u1, u2;
  logic          a1, a2;
  logic          z1, z2;
  logic          ut1, ut2;
  logic          zt1, zt2;
  logic [2:0]    enc_data;
  logic [AW:0]   pi_sum, g_sum;
  logic [AW-1:0] pi_next, g_next;
  logic          advance;

  always_comb begin
    u1 = buf_mem[icnt_reg];
    u2 = buf_mem[pi_reg];

    a1 = u1 ^ rsc1_reg[1] ^ rsc1_reg[2];
    z1 = a1 ^ rsc1_reg[0] ^ rsc1_reg[2];
    a2 = u2 ^ rsc2_reg[1] ^ rsc2_reg[2];
    z2 = a2 ^ rsc2_reg[0] ^ rsc2_reg[2];

    // Termination input u = s2^s3 cancels the feedback, so a = 0 and the
    // shift register flushes to zero in three steps.
    ut1 = rsc1_reg[1] ^ rsc1_reg[2];
    zt1 = rsc1_reg[0] ^ rsc1_reg[2];
    ut2 = rsc2_reg[1] ^ rsc2_reg[2];
    zt2 = rsc2_reg[0] ^ rsc2_reg[2];

`ifdef TURBO_PUNCT_EN
    enc_data = {u1, (icnt_reg[0] ? z2 : z1), 1'b0};
`else
    enc_data = {u1, z1, z2};
`endif

    // pi and g are always < K, so one conditional subtract reduces mod K.
    pi_sum  = {1'b0, pi_reg} + {1'b0, g_reg};
    pi_next = (pi_sum >= K_W) ? AW'(pi_sum - K_W) : AW'(pi_sum);
    g_sum   = {1'b0, g_reg} + GSTEP_W;
    g_next  = (g_sum >= K_W) ? AW'(g_sum - K_W) : AW'(g_sum);

    // Single output register: refill whenever it is empty or being drained.
    advance = !out_valid_reg || bus.out_ready;
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= LOAD;
      wcnt_reg      <= '0;
      icnt_reg      <= '0;
      pi_reg        <= '0;
      g_reg         <= '0;
      tcnt_reg      <= '0;
      rsc1_reg      <= '0;
      rsc2_reg      <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tail_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            if (wcnt_reg == LAST_A) begin
              wcnt_reg     <= '0;
              in_ready_reg <= 1'b0;
              icnt_reg     <= '0;
              pi_reg       <= '0;
              g_reg        <= GINIT_A;
              state_reg    <= ENC;
            end else begin
              wcnt_reg <= wcnt_reg + 1'b1;
            end
          end
        end

        ENC: begin
          if (advance) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= enc_data;
            out_tail_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
            rsc1_reg      <= {rsc1_reg[1], rsc1_reg[0], a1};
            rsc2_reg      <= {rsc2_reg[1], rsc2_reg[0], a2};
            pi_reg        <= pi_next;
            g_reg         <= g_next;
            if (icnt_reg == LAST_A) begin
              icnt_reg  <= '0;
              tcnt_reg  <= '0;
              state_reg <= TERM1;
            end else begin
              icnt_reg <= icnt_reg + 1'b1;
            end
          end
        end

        TERM1: begin
          if (advance) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= {ut1, zt1, 1'b0};
            out_tail_reg  <= 1'b1;
            out_last_reg  <= 1'b0;
            rsc1_reg      <= {rsc1_reg[1], rsc1_reg[0], 1'b0};
            if (tcnt_reg == 2'd2) begin
              tcnt_reg  <= '0;
              state_reg <= TERM2;
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end

        TERM2: begin
          // tcnt == 3 means the final symbol is loaded and waiting to drain.
          if (tcnt_reg == 2'd3) begin
            if (bus.out_ready) begin
              out_valid_reg <= 1'b0;
              out_tail_reg  <= 1'b0;
              out_last_reg  <= 1'b0;
              tcnt_reg      <= '0;
              in_ready_reg  <= 1'b1;
              state_reg     <= LOAD;
            end
          end else if (advance) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= {ut2, 1'b0, zt2};
            out_tail_reg  <= 1'b1;
            out_last_reg  <= (tcnt_reg == 2'd2);
            rsc2_reg      <= {rsc2_reg[1], rsc2_reg[0], 1'b0};
            tcnt_reg      <= tcnt_reg + 1'b1;
          end
        end

        default: state_reg <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_tail  = out_tail_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.busy      = (state_reg != LOAD);

endmodule

// File: doc/turbo_encoder_blk.md
Name: turbo_encoder_blk

Overview:
Parametrised rate-1/3 turbo encoder (PCCC) with block buffering. It accepts a serial block of K information bits, stores them, then emits systematic + RSC1 parity + RSC2 parity triplets per cycle. RSC2 runs on the QPP-interleaved sequence. Both encoders are trellis-terminated. The block sits between the bit source and the rate matcher/modulator, with valid/ready flow control on both sides.

Parameters:
K, 40, block length in bits (>=8); buffer depth
F1, 3, QPP interleaver coefficient f1 (pi(i) = (F1*i + F2*i*i) mod K)
F2, 10, QPP interleaver coefficient f2
AW, $clog2(K), address/counter width (derived; not for override)

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  input bit valid
in_ready  out  1  block can accept a bit
in_bit  in  1  information bit
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  3  {sys, p1, p2}; MSB = sys
out_tail  out  1  current output is a termination symbol
out_last  out  1  final symbol of the block
busy  out  1  high in any state other than LOAD

Behaviour:
- Reset: rst synchronous, active-low; clock clk. On reset: state=LOAD, counters=0, both RSC states=000, in_ready=0 for the cycle after reset release and 1 thereafter, out_valid=0, out_data=0, out_tail=0, out_last=0, busy=0.
- RSC (both identical): g0=1+D^2+D^3 (feedback), g1=1+D+D^3. State s1,s2,s3. a = u^s2^s3; z = a^s1^s3; update s3<=s2, s2<=s1, s1<=a.
- States: LOAD -> ENC -> TERM1 -> TERM2 -> LOAD.
- LOAD: in_ready=1. Each in_valid&in_ready handshake writes in_bit to buf[wcnt], then wcnt++. On the K-th accept: wcnt=0, in_ready drops the next cycle, state=ENC. Partial blocks are held indefinitely.
- ENC: for i=0..K-1, u1=buf[i] and u2=buf[pi(i)]. The output register loads {u1, z1, z2} and advances both RSCs only when the register is empty or out_ready=1 (skid-free, single output register). out_data holds stable while out_valid & !out_ready. The first out_valid occurs 1 cycle after entering ENC.
- QPP address: computed incrementally, with no multiplier. pi(0)=0, g(0)=(F1+F2) mod K, pi(i+1)=(pi(i)+g(i)) mod K, g(i+1)=(g(i)+2*F2) mod K. Each step is a modular add implemented as add + conditional subtract of K.
- TERM1: 3 symbols, u=s2^s3 of RSC1 (forces a=0). out_data={u,z1,0}, out_tail=1. RSC2 is frozen.
- TERM2: 3 symbols, the same procedure on RSC2. out_data={u,0,z2}, out_tail=1.
- After TERM2: out_last=1 on the 6th tail symbol. On its acceptance, both RSC states are already 000 and the block returns to LOAD.
- Total per block: K+6 output symbols.
- Reset mid-operation: aborts the block immediately; buffer contents are not cleared but are overwritten by the next block.
- No in_bit accepted while busy=1. The next block's LOAD begins the cycle after the last symbol is accepted.

Optional Feature:
TURBO_PUNCT_EN
- Defined: rate-1/2 puncturing during ENC. out_data={sys, p, 0}, where p=z1 for even i and z2 for odd i. Tail symbols are unchanged. The RSCs still advance on every symbol.
- Undefined: rate 1/3 as specified above; no puncturing logic present.

Test Plan:
- All-zero block (K=40): 40 accepted zeros -> 40 symbols 3'b000, then 6 tail symbols 3'b000, out_tail high for the last 6, out_last on the 46th symbol.
- Impulse at i=0: in_bit=1 at index 0, rest 0 -> p1 and p2 both 1,1,1,1,0 on symbols 0..4 (pi(0)=0). sys=1 only on symbol 0. Final RSC states after tail = 000.
- Interleaver check: single 1 at index 13 -> p2 impulse response starts at symbol 1 (pi(1)=13). p1 starts at symbol 13. Also verify pi(2)=6.
- Backpressure: random out_ready (50%) on a random block -> output stream is identical to the out_ready=1 run. out_data never changes while out_valid & !out_ready.
- Reset mid-ENC at symbol 20: rst low 1 cycle -> out_valid=0, busy=0, in_ready=1 next cycle. A new block encodes exactly like the golden model.
- With TURBO_PUNCT_EN, impulse at 0 -> symbols 0..4 = {1,1,0},{0,1,0},{0,1,0},{0,1,0},{0,0,0}. Tail is unchanged.
